// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide sequencer.
//   - 4-bit md opcodes decoded in the E stage
//   - sequencer state encoding
//   - default multiply/divide latencies
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Ops that occupy the unit for a multi-cycle latency.
    function automatic logic is_start_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational multiply / divide datapath.
// Ports:
//   op      - md opcode (only MULT/MULTU/DIV/DIVU produce a result)
//   rs, rt  - operands (rs = multiplicand / dividend, rt = divisor)
//   res_hi  - product[63:32] or remainder
//   res_lo  - product[31:0] or quotient
//   res_wr  - result should be committed (low for divide by zero)
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_wr
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               sdiv;
    logic               neg_q;
    logic               neg_r;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        div_b;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;

    assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign prod_u = {32'b0, rs} * {32'b0, rt};

    // Signed divide on magnitudes: quotient sign is the XOR of the operand
    // signs, remainder follows the dividend. 0x80000000 / -1 wraps back to
    // 0x80000000 naturally with this scheme.
    assign sdiv  = (op == MD_DIV);
    assign neg_r = sdiv & rs[31];
    assign neg_q = sdiv & (rs[31] ^ rt[31]);
    assign mag_a = neg_r ? -rs : rs;
    assign mag_b = (sdiv & rt[31]) ? -rt : rt;
    // Keep the divider well-defined on a zero divisor; the result is discarded.
    assign div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag = mag_a / div_b;
    assign r_mag = mag_a % div_b;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
        case (op)
            MD_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_wr = 1'b1;
            end
            MD_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_wr = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                res_lo = neg_q ? -q_mag : q_mag;
                res_hi = neg_r ? -r_mag : r_mag;
                res_wr = (rt != 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle multiply/divide sequencer owning HI/LO.
//
//   state | meaning
//   IDLE  | unit free; start-class ops launch, MTHI/MTLO write HI/LO
//   RUN   | op in flight; cnt counts down, commit when cnt reaches 1
//
// Ports:
//   clk, reset   - clock, async active-high reset
//   op           - E-stage md opcode
//   rs, rt       - forwarded E-stage operands
//   d_is_md      - instruction in D uses the unit
//   busy         - op in flight
//   md_stall     - stall request to the hazard unit
//   md_out       - HI for MFHI, LO for MFLO, else 0
//   hi, lo       - committed HI/LO
module muldiv_seq
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        d_is_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC    = CNT_W'(1);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      p_hi;
    logic [31:0]      p_lo;
    logic             p_wr;
    logic             start;
    logic [31:0]      ar_hi;
    logic [31:0]      ar_lo;
    logic             ar_wr;

    md_arith u_arith (
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .res_hi (ar_hi),
        .res_lo (ar_lo),
        .res_wr (ar_wr)
    );

    assign start    = (state == IDLE) && is_start_op(op);
    assign busy     = (state == RUN);
    assign md_stall = d_is_md & (start | busy);

    // No bypass of the pending result: reads see committed HI/LO only.
    always_comb begin
        md_out = 32'd0;
        if (op == MD_MFHI)
            md_out = hi;
        else if (op == MD_MFLO)
            md_out = lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            p_wr  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        p_hi  <= ar_hi;
                        p_lo  <= ar_lo;
                        p_wr  <= ar_wr;
                        cnt   <= ((op == MD_MULT) || (op == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
                        state <= RUN;
                    end else if (op == MD_MTHI) begin
                        hi <= rs;
                    end else if (op == MD_MTLO) begin
                        lo <= rs;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_TC) begin
                        state <= IDLE;
                        if (p_wr) begin
                            hi <= p_hi;
                            lo <= p_lo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        d_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .d_is_md  (d_is_md),
        .busy     (busy),
        .md_stall (md_stall),
        .md_out   (md_out),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy_n;
        int          stall_n;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts busy and md_stall cycles per op, compares on each commit.
    int   busy_cnt  = 0;
    int   stall_cnt = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            busy_cnt  = 0;
            stall_cnt = 0;
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL commit: unexpected commit, scoreboard empty");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, ".hi"}, hi, e.hi);
                    check({e.name, ".lo"}, lo, e.lo);
                    check({e.name, ".busy_cycles"}, 32'(busy_cnt), 32'(e.busy_n));
                    check({e.name, ".stall_cycles"}, 32'(stall_cnt), 32'(e.stall_n));
                end
                busy_cnt  = 0;
                stall_cnt = 0;
            end
            if (busy) busy_cnt++;
            if (md_stall) stall_cnt++;
            prev_busy = busy;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the first cycle with busy low.
    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        if (i == 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout waiting for busy to drop, busy=%b required 0", name, busy);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic d, input logic inject,
                          input logic [31:0] eh, input logic [31:0] el, input int eb);
        exp_t e;
        e.name    = name;
        e.hi      = eh;
        e.lo      = el;
        e.busy_n  = eb;
        e.stall_n = d ? eb + 1 : 0;
        sb.push_back(e);
        op      = o;
        rs      = a;
        rt      = b;
        d_is_md = d;
        @(posedge clk);
        #1;
        op = MD_NONE;
        rs = $urandom;
        rt = $urandom;
        if (inject) begin
            op = MD_MTLO;
            rs = 32'hDEADBEEF;
            @(posedge clk);
            #1;
            op = MD_DIV;
            rs = 32'd100;
            rt = 32'd3;
            @(posedge clk);
            #1;
            op = MD_NONE;
        end
        wait_idle(name);
        d_is_md = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        op      = MD_NONE;
        rs      = 32'd0;
        rt      = 32'd0;
        d_is_md = 1'b0;
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.md_stall", 32'(md_stall), 32'd0);
        check("rst.md_out", md_out, 32'd0);
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        run_op("mult", MD_MULT, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        op = MD_MFHI;
        #1;
        check("mfhi", md_out, 32'hFFFFFFFF);
        op = MD_MFLO;
        #1;
        check("mflo", md_out, 32'hFFFFFFFE);
        op = MD_NONE;
        #1;
        check("md_out_none", md_out, 32'd0);

        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFE, 5);
        run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000, 32'h80000000, 10);
        run_op("divu", MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b0, 32'd1, 32'd3, 10);
        run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, 1'b0, 1'b0, 32'd1, 32'd3, 10);

        op = MD_MTHI;
        rs = 32'h12345678;
        @(posedge clk);
        #1;
        op = MD_NONE;
        check("mthi.hi", hi, 32'h12345678);
        check("mthi.lo", lo, 32'd3);

        run_op("multu_inj", MD_MULTU, 32'd3, 32'd5, 1'b0, 1'b1, 32'd0, 32'd15, 5);

        // Reset on the 3rd busy cycle of a DIV; this op is never committed.
        op      = MD_DIV;
        rs      = 32'd100;
        rt      = 32'd7;
        d_is_md = 1'b1;
        @(posedge clk);
        #1;
        op = MD_NONE;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("abort.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.md_stall", 32'(md_stall), 32'd0);
        check("abort.hi", hi, 32'd0);
        check("abort.lo", lo, 32'd0);
        d_is_md = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_op("mult_post_rst", MD_MULT, 32'h00010000, 32'h00010000, 1'b1, 1'b0, 32'd1, 32'd0, 5);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
